// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide unit for the EX stage of the RV32 pipeline.
// Each accepted operation runs one bit per cycle: shift-add for MUL, restoring
// division for DIVU/REMU. The unit stalls the pipeline while it works and then
// presents a registered result together with a one-cycle done pulse.
//
// Ports:
//   clk     - core clock, rising edge
//   reset   - asynchronous active-high reset
//   start   - EX-stage instruction is an M-extension op (sampled in IDLE only)
//   funct3  - 000 MUL (low WIDTH bits), 101 DIVU, 111 REMU; others return 0
//   src_a   - multiplicand / dividend
//   src_b   - multiplier / divisor
//   flush   - synchronous abort from branch/jump flush
//   stall   - pipeline hold request
//   busy    - iterating
//   done    - one-cycle pulse, result valid
//   result  - registered result, changes only when an operation completes
//
// Optional build macro: MDU_EARLY_OUT_EN lets a MUL finish as soon as the
// remaining multiplier bits are all zero.
module mdu_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [2:0] F3Mul  = 3'b000;
  localparam logic [2:0] F3Divu = 3'b101;
  localparam logic [2:0] F3Remu = 3'b111;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   acc_q, acc_d;        // product accumulator / partial remainder
  logic [WIDTH-1:0] opa_q, opa_d;        // multiplicand / dividend-then-quotient
  logic [WIDTH-1:0] opb_q, opb_d;        // multiplier / divisor
  logic [2:0]       op_q, op_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             is_mul;
  logic             last;
  logic [WIDTH:0]   mul_acc;
  logic [WIDTH-1:0] mul_opa;
  logic [WIDTH-1:0] mul_opb;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic             no_borrow;
  logic [WIDTH:0]   div_rem;
  logic [WIDTH-1:0] div_quo;

  // One iteration of each datapath, computed from the current registers.
  always_comb begin
    is_mul  = (op_q == F3Mul);
    // Product is kept mod 2^WIDTH, so the accumulator's top bit stays zero for MUL.
    mul_acc = opb_q[0] ? {1'b0, acc_q[WIDTH-1:0] + opa_q} : acc_q;
    mul_opa = opa_q << 1;
    mul_opb = opb_q >> 1;
    // Dividend bits shift out of opa's top while quotient bits shift into its bottom.
    rem_sh    = {acc_q[WIDTH-1:0], opa_q[WIDTH-1]};
    diff      = {1'b0, rem_sh} - {2'b00, opb_q};
    no_borrow = ~diff[WIDTH+1];
    div_rem   = no_borrow ? diff[WIDTH:0] : rem_sh;
    div_quo   = {opa_q[WIDTH-2:0], no_borrow};
`ifdef MDU_EARLY_OUT_EN
    last = (cnt_q == CntW'(1)) || (is_mul && (mul_opb == '0));
`else
    last = (cnt_q == CntW'(1));
`endif
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          op_d    = funct3;
          opa_d   = src_a;
          opb_d   = src_b;
          acc_d   = '0;
          cnt_d   = CntW'(WIDTH);
          state_d = StRun;
          case (funct3)
            F3Mul: begin
`ifdef MDU_EARLY_OUT_EN
              if (src_b == '0) begin
                result_d = '0;
                state_d  = StDone;
              end
`endif
            end
            F3Divu: begin
              if (src_b == '0) begin
                result_d = '1;
                state_d  = StDone;
              end
            end
            F3Remu: begin
              if (src_b == '0) begin
                result_d = src_a;
                state_d  = StDone;
              end
            end
            default: begin
              result_d = '0;
              state_d  = StDone;
            end
          endcase
        end
      end
      StRun: begin
        cnt_d = cnt_q - CntW'(1);
        if (is_mul) begin
          acc_d = mul_acc;
          opa_d = mul_opa;
          opb_d = mul_opb;
        end else begin
          acc_d = div_rem;
          opa_d = div_quo;
        end
        if (last) begin
          state_d = StDone;
          if (is_mul) begin
            result_d = mul_acc[WIDTH-1:0];
          end else if (op_q == F3Divu) begin
            result_d = div_quo;
          end else begin
            result_d = div_rem[WIDTH-1:0];
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort wins everywhere: no done pulse and the previous result survives.
    if (flush) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    busy   = (state_q == StRun);
    done   = (state_q == StDone);
    stall  = busy || ((state_q == StIdle) && start && !flush);
    result = result_q;
  end

endmodule
